// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus of the memory access sequencer.
// The master (CPU datapath) issues a load/store; the slave (sequencer)
// reports busy, completion, fault and the captured load data.
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator-side sequencer between the MAR/MDR path and a synchronous RAM.
// Accepts one load or store at a time, strobes the RAM for exactly one
// cycle, captures registered read data and flags out-of-range addresses.
// Every output comes straight from a flop.
module mem_access_ctrl #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    mem_access_ctrl_if.slave     bus,
    output logic [ADDR_BITS-1:0] ram_address,
    output logic [31:0]          ram_data_in,
    output logic                 ram_write_enable,
    output logic                 ram_read_enable,
    input  logic [31:0]          ram_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [ADDR_BITS-1:0] ram_address_q, ram_address_d;
    logic [31:0]          ram_data_in_q, ram_data_in_d;
    logic                 ram_we_q, ram_we_d;
    logic                 ram_re_q, ram_re_d;
    logic                 out_of_range;

    // Any address bit above the RAM word-address width makes the request a fault.
    assign out_of_range = (bus.addr >> ADDR_BITS) != 32'd0;

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        ram_we_d      = ram_we_q;
        ram_re_d      = ram_re_q;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    ram_address_d = bus.addr[ADDR_BITS-1:0];
                    ram_data_in_d = bus.wdata;
                    busy_d        = 1'b1;
                    err_d         = 1'b0;
                    if (out_of_range) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (bus.we) begin
                        ram_we_d = 1'b1;
                        state_d  = WR_ISSUE;
                    end else begin
                        ram_re_d = 1'b1;
                        state_d  = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: begin
                ram_we_d = 1'b0;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            RD_ISSUE: begin
                ram_re_d = 1'b0;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_d = ram_data_out;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                ram_we_d = 1'b0;
                ram_re_d = 1'b0;
                done_d   = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access and drops strobes at once.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
            ram_we_q      <= 1'b0;
            ram_re_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            ram_address_q <= ram_address_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
            ram_re_q      <= ram_re_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.rdata        = rdata_q;
    assign ram_address      = ram_address_q;
    assign ram_data_in      = ram_data_in_q;
    assign ram_write_enable = ram_we_q;
    assign ram_read_enable  = ram_re_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side sequencer that drives the 256-word synchronous RAM on behalf of the CPU datapath. It accepts one load or store request at a time, with a 32-bit effective address and store data. It generates the RAM's registered write-enable and read-enable strobes and the 8-bit word address, then captures the RAM's registered read data. It sits between the MAR/MDR path and the RAM, and reports completion or an out-of-range fault to the control unit.

## Interface
Parameters:
- `ADDR_BITS`, 8: RAM word-address width. Addresses with any bit set above this width are out of range.

Ports:
- `clk`  in  1  system clock, rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe, sampled only in IDLE.
- `we`  in  1  request type: 1 = store, 0 = load. Sampled with `req`.
- `addr`  in  32  effective address (MAR). Sampled with `req`.
- `wdata`  in  32  store data (MDR). Sampled with `req`.
- `busy`  out  1  high from request acceptance until the cycle after `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  out-of-range fault. Valid with `done`, held until the next acceptance.
- `rdata`  out  32  captured load data. Held until the next successful load.
- `ram_address`  out  `ADDR_BITS`  RAM word address.
- `ram_data_in`  out  32  RAM write data.
- `ram_write_enable`  out  1  RAM write strobe.
- `ram_read_enable`  out  1  RAM read strobe.
- `ram_data_out`  in  32  RAM registered read data. Valid one edge after the read strobe is sampled.

## Operation
- All outputs are registered. The FSM states are IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE and DONE.
- IDLE with `req`=1:
  - Latch `addr[ADDR_BITS-1:0]` into `ram_address` and `wdata` into `ram_data_in`. Set `busy`=1 and `err`=0.
  - If `addr[31:ADDR_BITS]` is nonzero: no RAM strobe, `err`<=1, `done`<=1, go to DONE.
  - Else if `we`=1: `ram_write_enable`<=1, go to WR_ISSUE.
  - Else: `ram_read_enable`<=1, go to RD_ISSUE.
- WR_ISSUE: the RAM samples the write on this edge. `ram_write_enable`<=0, `done`<=1, go to DONE.
- RD_ISSUE: the RAM loads its output on this edge. `ram_read_enable`<=0, go to RD_WAIT.
- RD_WAIT: `rdata`<=`ram_data_out`, `done`<=1, go to DONE.
- DONE: `done`<=0, `busy`<=0, go to IDLE.
- Outside IDLE, `req`, `we`, `addr` and `wdata` are ignored. A held `req` is re-accepted in the first IDLE cycle.
- `ram_write_enable` and `ram_read_enable` are never high in the same cycle. Each is high for exactly one cycle per accepted request.
- `ram_address` and `ram_data_in` hold their values after the access and change only on acceptance.
- A faulted request leaves `rdata` unchanged.

## Timing
- Reset (`clr_n`=0, asynchronous): state IDLE; `busy`, `done`, `err`, `ram_write_enable` and `ram_read_enable` = 0; `rdata`, `ram_address` and `ram_data_in` = 0.
- Reset mid-operation aborts the access immediately. Any pending strobe drops in the same instant, no `done` is produced, and `rdata` clears.
- Edges are numbered from acceptance, E0 (IDLE, `req`=1):
  - Load: strobe high E0→E1, RAM captures data at E1, `rdata` is valid and `done`=1 E2→E3, IDLE after E3. Issue-to-issue throughput is 4 cycles.
  - Store: `ram_write_enable` high E0→E1, memory updated at E1, `done`=1 E1→E2, IDLE after E2. Throughput is 3 cycles.
  - Fault: `done`=`err`=1 E0→E1, IDLE after E1.
- `busy` rises at E0 and falls at the edge where `done` falls.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, no strobes. Assert `clr_n`=0 during RD_ISSUE → `ram_read_enable` drops immediately, no `done`.
- Store `addr`=0x00000034, `wdata`=0x000000BC, then load 0x34 → single-cycle `ram_write_enable` with `ram_address`=0x34; `done` 2 cycles after acceptance; load returns `rdata`=0x000000BC with `done` 3 cycles after acceptance.
- Load 0x54 from a model preloaded with 0x00000097 while holding `req`=1 continuously → `rdata`=0x97; requests are accepted every 4 cycles; `req` is ignored while `busy`.
- Load `addr`=0x00000154 → `done`=`err`=1 one cycle after acceptance, no RAM strobe, `rdata` keeps its previous value; next valid load clears `err`.
- Back-to-back store 0xFF←0xFFFFFFFF then load 0xFF → store completes before load issue; `rdata`=0xFFFFFFFF; top address does not wrap.
- Throughout all tests → `ram_write_enable` and `ram_read_enable` are never high together, and each strobe lasts exactly one cycle.
